// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache set and its per-way line storage.
package cache_pkg;

    localparam int unsigned DEF_TAG_WIDTH  = 30;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_WAYS       = 4;
    localparam int unsigned DEF_IDX_WIDTH  = $clog2(DEF_WAYS);

    typedef logic [DEF_IDX_WIDTH-1:0] way_idx_t;
    typedef logic [DEF_IDX_WIDTH-1:0] age_t;

    typedef struct packed {
        logic                      valid;
        logic                      dirty;
        logic [DEF_TAG_WIDTH-1:0]  tag;
        logic [DEF_DATA_WIDTH-1:0] data;
    } line_t;

endpackage

// File: rtl/cache_way.sv
// Storage for one cache line: valid/dirty/tag/data with fill, byte-enable store and tag match.
// Dirty bit is kept only when CACHE_SET_DIRTY_EN is defined.
module cache_way
    import cache_pkg::*;
#(
    parameter int unsigned TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inval,
    input  logic                    fill_we,
    input  logic [TAG_WIDTH-1:0]    fill_tag,
    input  logic [DATA_WIDTH-1:0]   fill_data,
    input  logic                    store_we,
    input  logic [DATA_WIDTH/8-1:0] store_be,
    input  logic [DATA_WIDTH-1:0]   store_data,
    input  logic [TAG_WIDTH-1:0]    lookup_tag,
    output logic                    match,
    output logic                    valid,
    output logic                    dirty,
    output logic [TAG_WIDTH-1:0]    tag,
    output logic [DATA_WIDTH-1:0]   data
);

    logic                  valid_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (inval) begin
            valid_q <= 1'b0;
        end else if (fill_we) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag;
            data_q  <= fill_data;
        end else if (store_we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (store_be[b]) data_q[b*8 +: 8] <= store_data[b*8 +: 8];
            end
        end
    end

`ifdef CACHE_SET_DIRTY_EN
    logic dirty_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty_q <= 1'b0;
        end else if (inval || fill_we) begin
            dirty_q <= 1'b0;
        end else if (store_we) begin
            dirty_q <= 1'b1;
        end
    end

    assign dirty = dirty_q;
`else
    assign dirty = 1'b0;
`endif

    assign match = valid_q && (tag_q == lookup_tag);
    assign valid = valid_q;
    assign tag   = tag_q;
    assign data  = data_q;

endmodule

// File: rtl/cache_set.sv
// N-way set-associative cache set with true-LRU ages and victim selection.
// Define CACHE_SET_DIRTY_EN for write-back dirty tracking; otherwise victim_dirty is always 0.
module cache_set
    import cache_pkg::*;
#(
    parameter int unsigned TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned WAYS       = DEF_WAYS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      lookup_en,
    input  logic [TAG_WIDTH-1:0]      lookup_tag,
    output logic                      hit,
    output logic [$clog2(WAYS)-1:0]   hit_way,
    output logic [DATA_WIDTH-1:0]     hit_data,
    input  logic                      store_en,
    input  logic [DATA_WIDTH/8-1:0]   store_be,
    input  logic [DATA_WIDTH-1:0]     store_data,
    output logic                      store_ack,
    input  logic                      fill_en,
    input  logic [TAG_WIDTH-1:0]      fill_tag,
    input  logic [DATA_WIDTH-1:0]     fill_data,
    output logic [$clog2(WAYS)-1:0]   victim_way,
    output logic                      victim_valid,
    output logic                      victim_dirty,
    output logic [TAG_WIDTH-1:0]      victim_tag,
    output logic [DATA_WIDTH-1:0]     victim_data,
    input  logic                      inval_all
);

    localparam int unsigned IDX_W = $clog2(WAYS);
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(WAYS - 1);

    logic [WAYS-1:0]       way_match;
    logic [WAYS-1:0]       way_valid;
    logic [WAYS-1:0]       way_dirty;
    logic [TAG_WIDTH-1:0]  way_tag  [WAYS];
    logic [DATA_WIDTH-1:0] way_data [WAYS];

    logic [IDX_W-1:0] age_q [WAYS];
    logic [IDX_W-1:0] age_d [WAYS];

    logic             touch_en;
    logic [IDX_W-1:0] touch_way;
    logic             found_invalid;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic fill_we;
        logic store_we;

        assign fill_we  = fill_en && !inval_all && (victim_way == IDX_W'(g));
        assign store_we = store_ack && (hit_way == IDX_W'(g));

        cache_way #(
            .TAG_WIDTH (TAG_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_way (
            .clk       (clk),
            .reset     (reset),
            .inval     (inval_all),
            .fill_we   (fill_we),
            .fill_tag  (fill_tag),
            .fill_data (fill_data),
            .store_we  (store_we),
            .store_be  (store_be),
            .store_data(store_data),
            .lookup_tag(lookup_tag),
            .match     (way_match[g]),
            .valid     (way_valid[g]),
            .dirty     (way_dirty[g]),
            .tag       (way_tag[g]),
            .data      (way_data[g])
        );
    end

    // Valid tags are unique, so at most one way matches and an OR-mux suffices.
    always_comb begin
        hit_way  = '0;
        hit_data = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (way_match[i]) begin
                hit_way  = hit_way | IDX_W'(i);
                hit_data = hit_data | way_data[i];
            end
        end
    end

    assign hit       = |way_match;
    assign store_ack = store_en && hit && !fill_en && !inval_all;

    always_comb begin
        victim_way    = '0;
        found_invalid = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                victim_way    = IDX_W'(i);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int i = 0; i < WAYS; i++) begin
                if (age_q[i] == AGE_MAX) victim_way = IDX_W'(i);
            end
        end
    end

    assign victim_valid = way_valid[victim_way];
    assign victim_dirty = way_dirty[victim_way];
    assign victim_tag   = way_tag[victim_way];
    assign victim_data  = way_data[victim_way];

    always_comb begin
        touch_en  = 1'b0;
        touch_way = '0;
        if (inval_all) begin
            touch_en = 1'b0;
        end else if (fill_en) begin
            touch_en  = 1'b1;
            touch_way = victim_way;
        end else if (store_ack || (lookup_en && hit)) begin
            touch_en  = 1'b1;
            touch_way = hit_way;
        end
    end

    // Touched way becomes MRU; everything younger than it ages by one.
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            age_d[i] = age_q[i];
            if (touch_en) begin
                if (IDX_W'(i) == touch_way) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[touch_way]) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WAYS; i++) age_q[i] <= IDX_W'(i);
        end else begin
            for (int i = 0; i < WAYS; i++) age_q[i] <= age_d[i];
        end
    end

endmodule
